row_uram_arbiter: RTL and testbench

Row-level arbiter and barrier for the shared URAM. It sits directly downstream of every core in a row: it consumes each core's lock-request handshake and gated URAM write bus, grants URAM ownership to one core at a time in round-robin order, and muxes the owner's writes onto the single URAM port. Once every core in the row has completed one ownership, it stops granting, requests an external drain of the URAM, and broadcasts `o_uram_emptied` when the drain completes.

---
 rtl/row_uram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_row_uram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_uram_arbiter.sv
// row_uram_arbiter
// Row-level URAM arbiter and barrier. Grants URAM ownership to one core at a
// time in round-robin order and muxes the owner's write bus onto the single
// URAM port. Once every core has completed one ownership it stops granting,
// requests an external drain and broadcasts o_uram_emptied when the drain ends.
//
// Ports
//   clk, reset             : clock, synchronous active-low reset
//   i_core_req/_locked     : per-core ownership request / still-using flag
//   o_core_grant           : one-hot or zero grant
//   o_uram_emptied         : barrier released
//   i_core_uram_*          : per-core URAM bus (zero when not granted)
//   o_uram_*               : registered URAM port (OR of per-core buses)
//   o_drain_req            : ask external reader to empty the URAM
//   i_drain_done           : single-cycle drain-complete pulse
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | looking for an eligible core, or all served -> drain
// S_GRANT   | owner holds URAM until req and locked both drop
// S_RELEASE | one dead cycle with no grant
// S_DRAIN   | o_drain_req high, waiting for i_drain_done
// S_EMPTIED | barrier released, o_uram_emptied high until next grant
module row_uram_arbiter #(
    parameter int NUM_CORES   = 8,
    parameter int URAM_ADDR_W = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            i_core_req,
    input  logic [NUM_CORES-1:0]            i_core_locked,
    output logic [NUM_CORES-1:0]            o_core_grant,
    output logic                            o_uram_emptied,
    input  logic [NUM_CORES-1:0]            i_core_uram_en,
    input  logic [NUM_CORES*URAM_ADDR_W-1:0] i_core_uram_addr,
    input  logic [NUM_CORES*32-1:0]         i_core_uram_wr_data,
    input  logic [NUM_CORES-1:0]            i_core_uram_wr_en,
    output logic                            o_uram_en,
    output logic [URAM_ADDR_W-1:0]          o_uram_addr,
    output logic [31:0]                     o_uram_wr_data,
    output logic                            o_uram_wr_en,
    output logic                            o_drain_req,
    input  logic                            i_drain_done
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE,
        S_DRAIN,
        S_EMPTIED
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PW-1:0]          owner_q, owner_d;
    logic [NUM_CORES-1:0]   served_q, served_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;
    logic                   emptied_q, emptied_d;
    logic                   drain_req_q, drain_req_d;
    logic                   uram_en_q, uram_en_d;
    logic                   uram_wr_en_q, uram_wr_en_d;
    logic [URAM_ADDR_W-1:0] uram_addr_q, uram_addr_d;
    logic [31:0]            uram_data_q, uram_data_d;

    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   elig_rot;
    logic                   pick_found;
    logic [PW-1:0]          pick_off;
    logic [PW:0]            pick_sum;
    logic [PW-1:0]          pick_idx;

    assign eligible = i_core_req & ~served_q;

    // Rotate eligibility so bit 0 is the core at ptr, take the lowest set bit,
    // then rotate the offset back into an absolute core index.
    always_comb begin
        elig_rot   = NUM_CORES'({eligible, eligible} >> ptr_q);
        pick_found = 1'b0;
        pick_off   = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (!pick_found && elig_rot[j]) begin
                pick_found = 1'b1;
                pick_off   = PW'(j);
            end
        end
        pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
        if (pick_sum >= (PW+1)'(NUM_CORES)) begin
            pick_sum = pick_sum - (PW+1)'(NUM_CORES);
        end
        pick_idx = pick_sum[PW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        served_d    = served_q;
        grant_d     = grant_q;
        emptied_d   = emptied_q;
        drain_req_d = drain_req_q;
        case (state_q)
            S_IDLE, S_EMPTIED: begin
                if (&served_q) begin
                    state_d     = S_DRAIN;
                    drain_req_d = 1'b1;
                end else if (pick_found) begin
                    state_d   = S_GRANT;
                    owner_d   = pick_idx;
                    grant_d   = NUM_CORES'(1) << pick_idx;
                    emptied_d = 1'b0;
                end
            end
            S_GRANT: begin
                if (!(i_core_req[owner_q] || i_core_locked[owner_q])) begin
                    state_d           = S_RELEASE;
                    grant_d           = '0;
                    served_d[owner_q] = 1'b1;
                    ptr_d = (owner_q == PW'(NUM_CORES-1)) ? '0 : owner_q + PW'(1);
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (i_drain_done) begin
                    state_d     = S_EMPTIED;
                    served_d    = '0;
                    emptied_d   = 1'b1;
                    drain_req_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Non-granted cores drive zero, so OR-reduction is the mux.
    always_comb begin
        uram_en_d    = |i_core_uram_en;
        uram_wr_en_d = |i_core_uram_wr_en;
        uram_addr_d  = '0;
        uram_data_d  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            uram_addr_d = uram_addr_d | i_core_uram_addr[k*URAM_ADDR_W +: URAM_ADDR_W];
            uram_data_d = uram_data_d | i_core_uram_wr_data[k*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            served_q     <= '0;
            grant_q      <= '0;
            emptied_q    <= 1'b0;
            drain_req_q  <= 1'b0;
            uram_en_q    <= 1'b0;
            uram_wr_en_q <= 1'b0;
            uram_addr_q  <= '0;
            uram_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            served_q     <= served_d;
            grant_q      <= grant_d;
            emptied_q    <= emptied_d;
            drain_req_q  <= drain_req_d;
            uram_en_q    <= uram_en_d;
            uram_wr_en_q <= uram_wr_en_d;
            uram_addr_q  <= uram_addr_d;
            uram_data_q  <= uram_data_d;
        end
    end

    assign o_core_grant   = grant_q;
    assign o_uram_emptied = emptied_q;
    assign o_drain_req    = drain_req_q;
    assign o_uram_en      = uram_en_q;
    assign o_uram_wr_en   = uram_wr_en_q;
    assign o_uram_addr    = uram_addr_q;
    assign o_uram_wr_data = uram_data_q;

endmodule

// File: tb/tb_row_uram_arbiter.sv
// Testbench for row_uram_arbiter with NUM_CORES=4. The URAM port is checked
// every cycle against a scoreboard of expected values queued when the core
// buses are driven; grant/barrier outputs are checked at directed points.
module tb_row_uram_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;

    logic            clk;
    logic            reset;
    logic [N-1:0]    i_core_req;
    logic [N-1:0]    i_core_locked;
    logic [N-1:0]    o_core_grant;
    logic            o_uram_emptied;
    logic [N-1:0]    i_core_uram_en;
    logic [N*AW-1:0] i_core_uram_addr;
    logic [N*32-1:0] i_core_uram_wr_data;
    logic [N-1:0]    i_core_uram_wr_en;
    logic            o_uram_en;
    logic [AW-1:0]   o_uram_addr;
    logic [31:0]     o_uram_wr_data;
    logic            o_uram_wr_en;
    logic            o_drain_req;
    logic            i_drain_done;

    int checks = 0;
    int errors = 0;
    logic [45:0] sb_q[$];

    row_uram_arbiter #(.NUM_CORES(N), .URAM_ADDR_W(AW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_core_req          (i_core_req),
        .i_core_locked       (i_core_locked),
        .o_core_grant        (o_core_grant),
        .o_uram_emptied      (o_uram_emptied),
        .i_core_uram_en      (i_core_uram_en),
        .i_core_uram_addr    (i_core_uram_addr),
        .i_core_uram_wr_data (i_core_uram_wr_data),
        .i_core_uram_wr_en   (i_core_uram_wr_en),
        .o_uram_en           (o_uram_en),
        .o_uram_addr         (o_uram_addr),
        .o_uram_wr_data      (o_uram_wr_data),
        .o_uram_wr_en        (o_uram_wr_en),
        .o_drain_req         (o_drain_req),
        .i_drain_done        (i_drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [45:0] uram_expect();
        logic [AW-1:0] a;
        logic [31:0]   d;
        a = '0;
        d = '0;
        for (int k = 0; k < N; k++) begin
            a = a | i_core_uram_addr[k*AW +: AW];
            d = d | i_core_uram_wr_data[k*32 +: 32];
        end
        return {|i_core_uram_en, |i_core_uram_wr_en, a, d};
    endfunction

    // One clock: queue what the URAM port must show after this edge, advance,
    // then compare the registered port against the queued value.
    task automatic tick();
        logic [45:0] e;
        e = reset ? uram_expect() : 46'd0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chk("uram_port", {o_uram_en, o_uram_wr_en, o_uram_addr, o_uram_wr_data}, sb_q.pop_front());
    endtask

    task automatic set_bus(input int k, input logic en, input logic wr,
                           input logic [AW-1:0] addr, input logic [31:0] data);
        i_core_uram_en      = '0;
        i_core_uram_wr_en   = '0;
        i_core_uram_addr    = '0;
        i_core_uram_wr_data = '0;
        i_core_uram_en[k]                 = en;
        i_core_uram_wr_en[k]              = wr;
        i_core_uram_addr[k*AW +: AW]      = addr;
        i_core_uram_wr_data[k*32 +: 32]   = data;
    endtask

    task automatic clear_bus();
        i_core_uram_en      = '0;
        i_core_uram_wr_en   = '0;
        i_core_uram_addr    = '0;
        i_core_uram_wr_data = '0;
    endtask

    initial begin
        reset         = 1'b0;
        i_core_req    = '0;
        i_core_locked = '0;
        i_drain_done  = 1'b0;
        clear_bus();

        // Reset with random inputs: every output held at zero.
        for (int c = 0; c < 3; c++) begin
            i_core_req          = N'($urandom);
            i_core_locked       = N'($urandom);
            i_drain_done        = 1'($urandom);
            i_core_uram_en      = N'($urandom);
            i_core_uram_wr_en   = N'($urandom);
            i_core_uram_addr    = {$urandom, $urandom};
            i_core_uram_wr_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("rst_grant", 64'(o_core_grant), 64'd0);
            chk("rst_emptied", 64'(o_uram_emptied), 64'd0);
            chk("rst_drain_req", 64'(o_drain_req), 64'd0);
        end
        i_core_req    = '0;
        i_core_locked = '0;
        i_drain_done  = 1'b0;
        clear_bus();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_no_grant", 64'(o_core_grant), 64'd0);
        end

        // Single core ownership: core 2.
        i_core_req[2] = 1'b1;
        tick();
        chk("single_grant", 64'(o_core_grant), 64'h4);
        set_bus(2, 1'b1, 1'b1, 12'h123, 32'hDEADBEEF);
        tick();
        chk("single_addr", 64'(o_uram_addr), 64'h123);
        chk("single_data", 64'(o_uram_wr_data), 64'hDEADBEEF);
        clear_bus();
        i_core_req[2]    = 1'b0;
        i_core_locked[2] = 1'b1;
        tick();
        chk("locked_holds", 64'(o_core_grant), 64'h4);
        // Release while still writing: the write is still forwarded.
        i_core_locked[2] = 1'b0;
        set_bus(2, 1'b1, 1'b1, 12'h7FF, 32'hCAFE0001);
        tick();
        chk("single_release", 64'(o_core_grant), 64'h0);
        chk("late_write_en", 64'(o_uram_wr_en), 64'h1);
        clear_bus();
        tick();

        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst2_grant", 64'(o_core_grant), 64'h0);

        // Round robin over all four cores; core 0 re-requests while core 1 owns.
        i_core_req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            tick();
            chk($sformatf("rr_grant%0d", k), 64'(o_core_grant), 64'(1 << k));
            tick();
            chk($sformatf("rr_hold%0d", k), 64'(o_core_grant), 64'(1 << k));
            if (k == 1) begin
                i_core_req[0] = 1'b1;
                tick();
                chk("barrier_no_regrant", 64'(o_core_grant), 64'h2);
            end
            i_core_req[k] = 1'b0;
            if (k == 0) begin
                tick();
                chk("rr_rel0", 64'(o_core_grant), 64'h0);
                i_core_req[0] = 1'b0;
            end else begin
                tick();
                chk($sformatf("rr_rel%0d", k), 64'(o_core_grant), 64'h0);
            end
            tick();
            chk($sformatf("rr_dead%0d", k), 64'(o_core_grant), 64'h0);
            if (k == N-1) begin
                chk("drain_not_yet", 64'(o_drain_req), 64'h0);
            end
        end
        tick();
        chk("drain_req_up", 64'(o_drain_req), 64'h1);
        chk("drain_no_grant", 64'(o_core_grant), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("drain_wait_grant", 64'(o_core_grant), 64'h0);
            chk("drain_wait_req", 64'(o_drain_req), 64'h1);
            chk("drain_wait_emptied", 64'(o_uram_emptied), 64'h0);
        end
        i_drain_done = 1'b1;
        tick();
        i_drain_done = 1'b0;
        chk("emptied_up", 64'(o_uram_emptied), 64'h1);
        chk("drain_req_down", 64'(o_drain_req), 64'h0);
        chk("emptied_no_grant", 64'(o_core_grant), 64'h0);
        tick();
        chk("post_barrier_grant", 64'(o_core_grant), 64'h1);
        chk("emptied_down", 64'(o_uram_emptied), 64'h0);

        // Stray drain pulse while granted.
        i_drain_done = 1'b1;
        tick();
        i_drain_done = 1'b0;
        chk("stray_grant", 64'(o_core_grant), 64'h1);
        chk("stray_emptied", 64'(o_uram_emptied), 64'h0);
        chk("stray_drain_req", 64'(o_drain_req), 64'h0);
        tick();
        chk("stray_grant2", 64'(o_core_grant), 64'h1);

        // Reset while core 1 owns and writes; afterwards ptr restarts at 0.
        i_core_req[0] = 1'b0;
        tick();
        tick();
        i_core_req[1] = 1'b1;
        tick();
        chk("pre_rst_grant", 64'(o_core_grant), 64'h2);
        set_bus(1, 1'b1, 1'b1, 12'h0AB, 32'h12345678);
        tick();
        chk("pre_rst_en", 64'(o_uram_en), 64'h1);
        reset = 1'b0;
        tick();
        chk("midrst_grant", 64'(o_core_grant), 64'h0);
        chk("midrst_en", 64'(o_uram_en), 64'h0);
        chk("midrst_wr_en", 64'(o_uram_wr_en), 64'h0);
        reset = 1'b1;
        clear_bus();
        i_core_req = 4'b0011;
        tick();
        chk("post_rst_grant", 64'(o_core_grant), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
